// File: rtl/data_stack_pkg.sv
// Shared datapath constants and the stack operation decode used by the
// data stack that feeds the TR source mux.
package data_stack_pkg;

  localparam int DATA_W      = 16;
  localparam int STACK_DEPTH = 32;
  localparam int STACK_PTR_W = 5;

  // TR source mux select for the datastack read_data input.
  localparam logic [2:0] TRSRC_STACK = 3'd4;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_REPLACE,
    OP_PUSH,
    OP_POP
  } stack_op_e;

  // Clear wins over everything; push with pop is a replace of the top.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic clear);
    if (clear)        return OP_CLEAR;
    if (push && pop)  return OP_REPLACE;
    if (push)         return OP_PUSH;
    if (pop)          return OP_POP;
    return OP_HOLD;
  endfunction

endpackage

// File: rtl/data_stack_ram.sv
// DEPTH x DATA_W register array: one synchronous write port and two
// combinational read ports for the top and next-to-top entries.
module data_stack_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 32,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr1_i,
  input  logic [AW-1:0]     raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the array has no reset; visibility is governed by the stack
  // pointer, so stale contents are never observed and no reset tree is paid for.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = mem[raddr1_i];
  assign rdata2_o = mem[raddr2_i];

endmodule

// File: rtl/data_stack.sv
// LIFO data stack beside the TR register: zero-latency peek of the top two
// entries, saturating pointer, and sticky overflow/underflow flags.
module data_stack #(
  parameter int DATA_W = data_stack_pkg::DATA_W,
  parameter int DEPTH  = data_stack_pkg::STACK_DEPTH,
  parameter int PTR_W  = data_stack_pkg::STACK_PTR_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic              clear,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] read_data2,
  output logic [PTR_W:0]    count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);
  import data_stack_pkg::*;

  localparam logic [PTR_W:0] SP_ONE  = 1;
  localparam logic [PTR_W:0] SP_TWO  = 2;
  localparam logic [PTR_W:0] SP_FULL = (PTR_W+1)'(DEPTH);

  logic [PTR_W:0]    sp_q, sp_d, sp_m1, sp_m2;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              we;
  logic [PTR_W-1:0]  waddr;
  logic [DATA_W-1:0] rdata1, rdata2;
  stack_op_e         op;

  assign op    = decode_op(push, pop, clear);
  assign sp_m1 = sp_q - SP_ONE;
  assign sp_m2 = sp_q - SP_TWO;
  assign empty = (sp_q == '0);
  assign full  = (sp_q == SP_FULL);

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    we    = 1'b0;
    waddr = sp_q[PTR_W-1:0];
    unique case (op)
      OP_CLEAR: begin
        sp_d  = '0;
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      OP_REPLACE: begin
        we = 1'b1;
        if (empty) begin
          // Pop of nothing is flagged, then the push still lands in slot 0.
          unf_d = 1'b1;
          waddr = '0;
          sp_d  = SP_ONE;
        end else begin
          waddr = sp_m1[PTR_W-1:0];
        end
      end
      OP_PUSH: begin
        if (full) begin
          ovf_d = 1'b1;
        end else begin
          we   = 1'b1;
          sp_d = sp_q + SP_ONE;
        end
      end
      OP_POP: begin
        if (empty) unf_d = 1'b1;
        else       sp_d  = sp_m1;
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  data_stack_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (PTR_W)
  ) u_ram (
    .clk      (CLK),
    .we_i     (we),
    .waddr_i  (waddr),
    .wdata_i  (write_data),
    .raddr1_i (sp_m1[PTR_W-1:0]),
    .raddr2_i (sp_m2[PTR_W-1:0]),
    .rdata1_o (rdata1),
    .rdata2_o (rdata2)
  );

  // Hide stale array contents below the visible depth.
  assign read_data  = (sp_q >= SP_ONE) ? rdata1 : '0;
  assign read_data2 = (sp_q >= SP_TWO) ? rdata2 : '0;
  assign count      = sp_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: directed vector table, hand-written
// boundary sequences, and random traffic against a queue-based model.
module tb_data_stack;

  localparam int DW    = 16;
  localparam int DEPTH = 32;
  localparam int PW    = 5;

  logic          clk;
  logic          rst_n;
  logic          push, pop, clear;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data, read_data2;
  logic [PW:0]   count;
  logic          empty, full, overflow, underflow;

  int total = 0;
  int bad   = 0;

  // Reference model: the visible stack as a queue, bottom at index 0.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf;

  typedef struct packed {
    logic          push;
    logic          pop;
    logic          clear;
    logic [DW-1:0] wd;
    logic [PW:0]   cnt;
    logic [DW-1:0] rd;
    logic [DW-1:0] rd2;
    logic          ovf;
    logic          unf;
  } vec_t;

  vec_t vecs[15];

  data_stack dut (
    .CLK        (clk),
    .reset      (rst_n),
    .push       (push),
    .pop        (pop),
    .clear      (clear),
    .write_data (write_data),
    .read_data  (read_data),
    .read_data2 (read_data2),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic p, input logic o, input logic c,
                              input logic [DW-1:0] wd, input int cnt,
                              input logic [DW-1:0] rd, input logic [DW-1:0] rd2,
                              input logic ovf, input logic unf);
    vec_t v;
    v.push = p; v.pop = o; v.clear = c; v.wd = wd;
    v.cnt = (PW+1)'(cnt); v.rd = rd; v.rd2 = rd2; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  task automatic model_step(input logic p, input logic o, input logic c, input logic [DW-1:0] wd);
    if (c) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
    end else if (p && o) begin
      if (mq.size() == 0) begin
        m_unf = 1;
        mq.push_back(wd);
      end else begin
        mq[mq.size()-1] = wd;
      end
    end else if (p) begin
      if (mq.size() < DEPTH) mq.push_back(wd);
      else                   m_ovf = 1;
    end else if (o) begin
      if (mq.size() > 0) void'(mq.pop_back());
      else               m_unf = 1;
    end
  endtask

  task automatic check_model(input string tag);
    int n;
    logic [DW-1:0] e_rd, e_rd2;
    n     = mq.size();
    e_rd  = (n >= 1) ? mq[n-1] : '0;
    e_rd2 = (n >= 2) ? mq[n-2] : '0;
    check({tag, ".count"},     32'(count),      32'(n));
    check({tag, ".empty"},     32'(empty),      32'(n == 0));
    check({tag, ".full"},      32'(full),       32'(n == DEPTH));
    check({tag, ".read_data"}, 32'(read_data),  32'(e_rd));
    check({tag, ".read_data2"},32'(read_data2), 32'(e_rd2));
    check({tag, ".overflow"},  32'(overflow),   32'(m_ovf));
    check({tag, ".underflow"}, 32'(underflow),  32'(m_unf));
  endtask

  // Drive at the falling edge, let one rising edge act, sample at the next falling edge.
  task automatic apply(input logic p, input logic o, input logic c, input logic [DW-1:0] wd);
    push = p; pop = o; clear = c; write_data = wd;
    @(posedge clk);
    model_step(p, o, c, wd);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clear = 1'b0;
  endtask

  initial begin
    push = 0; pop = 0; clear = 0; write_data = '0;
    rst_n = 1'b0;
    mq.delete(); m_ovf = 0; m_unf = 0;

    // Reset state, observed before any clock edge.
    #3;
    check("rst.count", 32'(count), 32'd0);
    check("rst.empty", 32'(empty), 32'd1);
    check("rst.full",  32'(full),  32'd0);
    check("rst.rd",    32'(read_data),  32'h0);
    check("rst.rd2",   32'(read_data2), 32'h0);
    check("rst.ovf",   32'(overflow),   32'd0);
    check("rst.unf",   32'(underflow),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_model("idle");

    //                p  o  c  wd        cnt rd        rd2      ovf unf
    vecs[0]  = mk(1, 0, 0, 16'h1111, 1, 16'h1111, 16'h0000, 0, 0);
    vecs[1]  = mk(1, 0, 0, 16'h2222, 2, 16'h2222, 16'h1111, 0, 0);
    vecs[2]  = mk(1, 0, 0, 16'h3333, 3, 16'h3333, 16'h2222, 0, 0);
    vecs[3]  = mk(0, 1, 0, 16'h0000, 2, 16'h2222, 16'h1111, 0, 0);
    vecs[4]  = mk(0, 1, 0, 16'h0000, 1, 16'h1111, 16'h0000, 0, 0);
    vecs[5]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[6]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0, 1);
    vecs[7]  = mk(1, 0, 0, 16'hA5A5, 1, 16'hA5A5, 16'h0000, 0, 1);
    vecs[8]  = mk(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[9]  = mk(1, 0, 0, 16'h0001, 1, 16'h0001, 16'h0000, 0, 0);
    vecs[10] = mk(1, 0, 0, 16'h0002, 2, 16'h0002, 16'h0001, 0, 0);
    vecs[11] = mk(1, 1, 0, 16'h00FF, 2, 16'h00FF, 16'h0001, 0, 0);
    vecs[12] = mk(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);
    vecs[13] = mk(1, 1, 0, 16'h7777, 1, 16'h7777, 16'h0000, 0, 1);
    vecs[14] = mk(0, 0, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0, 0);

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i].push, vecs[i].pop, vecs[i].clear, vecs[i].wd);
      check($sformatf("vec%0d.count", i), 32'(count),      32'(vecs[i].cnt));
      check($sformatf("vec%0d.rd", i),    32'(read_data),  32'(vecs[i].rd));
      check($sformatf("vec%0d.rd2", i),   32'(read_data2), 32'(vecs[i].rd2));
      check($sformatf("vec%0d.ovf", i),   32'(overflow),   32'(vecs[i].ovf));
      check($sformatf("vec%0d.unf", i),   32'(underflow),  32'(vecs[i].unf));
      check($sformatf("vec%0d.empty", i), 32'(empty),      32'(vecs[i].cnt == 0));
    end

    // Fill to DEPTH with 0..31, then one push too many.
    for (int i = 0; i < DEPTH; i++) apply(1, 0, 0, DW'(i));
    check("fill.count", 32'(count), 32'd32);
    check("fill.full",  32'(full),  32'd1);
    check("fill.ovf",   32'(overflow), 32'd0);
    apply(1, 0, 0, 16'hBEEF);
    check("ovf.count", 32'(count),     32'd32);
    check("ovf.full",  32'(full),      32'd1);
    check("ovf.flag",  32'(overflow),  32'd1);
    check("ovf.rd",    32'(read_data), 32'h001F);
    check("ovf.rd2",   32'(read_data2),32'h001E);
    apply(0, 1, 0, 16'h0000);
    check("ovfpop.flag", 32'(overflow),  32'd1);
    check("ovfpop.rd",   32'(read_data), 32'h001E);
    check("ovfpop.full", 32'(full),      32'd0);

    // Down to five entries with overflow still set, then clear beats push.
    for (int i = 0; i < 26; i++) apply(0, 1, 0, 16'h0000);
    check("five.count", 32'(count),    32'd5);
    check("five.ovf",   32'(overflow), 32'd1);
    check("five.rd",    32'(read_data),32'h0004);
    apply(1, 0, 1, 16'hDEAD);
    check("clr.count", 32'(count),     32'd0);
    check("clr.ovf",   32'(overflow),  32'd0);
    check("clr.empty", 32'(empty),     32'd1);
    check("clr.rd",    32'(read_data), 32'h0);

    // Asynchronous reset in the middle of a push burst.
    apply(1, 0, 0, 16'h0A0A);
    apply(1, 0, 0, 16'h0B0B);
    apply(1, 0, 0, 16'h0C0C);
    check("burst.count", 32'(count), 32'd3);
    push = 1'b1; write_data = 16'h0D0D;
    #2 rst_n = 1'b0;
    #1;
    check("arst.count", 32'(count),      32'd0);
    check("arst.empty", 32'(empty),      32'd1);
    check("arst.rd",    32'(read_data),  32'h0);
    check("arst.rd2",   32'(read_data2), 32'h0);
    mq.delete(); m_ovf = 0; m_unf = 0;
    @(negedge clk);
    check("arst.hold", 32'(count), 32'd0);
    push = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_model("post_arst");

    // Random traffic; push bias alternates so both ends get exercised.
    for (int i = 0; i < 3000; i++) begin
      int pp;
      logic p, o, c;
      pp = ((i / 250) % 2 == 0) ? 75 : 30;
      p  = ($urandom_range(99, 0) < pp);
      o  = ($urandom_range(99, 0) < (100 - pp));
      c  = ($urandom_range(199, 0) == 0);
      apply(p, o, c, DW'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
